pulse_stretch: RTL and testbench
================================

// Module: pulse_stretch
// PURPOSE
//   Inverse of our level-to-pulse edge detector: turns single-cycle request pulses into
//   fixed-width output levels, with a guaranteed minimum low gap between them.
//   Drives remote-side outputs (LED, IR/buzzer enable) that need visible or long strobes.
//   Requests arriving while busy are queued and replayed, or dropped; see CONFIGURATION.
// PARAMETERS
//   HIGH_CYCLES  4  clk cycles level_out stays high per request (1 .. 2**CNT_W-1)
//   GAP_CYCLES   2  min clk cycles level_out stays low between requests (0 .. 2**CNT_W-1)
//   CNT_W        8  width of internal cycle timer
//   PEND_W       4  width of pending-request counter
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   in_pulse   in   1       request; one-cycle pulse, synchronous to clk
//   level_out  out  1       stretched output level, registered
//   busy       out  1       high in HIGH or GAP state, registered
//   pend_cnt   out  PEND_W  queued requests not yet served
//   drop       out  1       one-cycle pulse, cycle after a request is lost
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, level_out=0, busy=0, pend_cnt=0, drop=0, timer=0.
//     Applies immediately mid-HIGH/GAP. All pending requests discarded.
//   - FSM states IDLE, HIGH, GAP; level_out = (state==HIGH), busy = (state!=IDLE).
//   - IDLE: in_pulse=1 -> HIGH on next edge, timer loaded HIGH_CYCLES-1.
//     Latency: level_out rises the cycle after in_pulse.
//   - HIGH: timer decrements; at timer==0 -> GAP (timer loaded GAP_CYCLES-1).
//     If GAP_CYCLES==0, go straight to the HIGH/IDLE decision below.
//     level_out is high for exactly HIGH_CYCLES cycles.
//   - GAP: timer decrements; at timer==0:
//     pend_cnt>0 -> HIGH and pend_cnt-1; else -> IDLE.
//   - GAP_CYCLES==0 with pending requests: consecutive HIGH windows merge into one
//     continuous level (accepted behaviour).
//   - in_pulse while busy: handled per CONFIGURATION.
//   - Same cycle as a dequeue: increment and decrement cancel, pend_cnt unchanged.
//   - In IDLE, pend_cnt is always 0. in_pulse in IDLE never touches pend_cnt.
//   - drop is registered: high for exactly one cycle per lost request.
// CONFIGURATION
//   Macro PULSE_STRETCH_QUEUE_EN
//   - Defined: in_pulse while busy increments pend_cnt, saturating at 2**PEND_W-1.
//     A request arriving at saturation is lost -> drop.
//   - Undefined: in_pulse while busy is always lost -> drop.
//     pend_cnt tied to 0; no counter logic is synthesised.
// STRUCTURE
//   - Package pulse_stretch_pkg: state typedef (IDLE/HIGH/GAP, 2-bit encoding) and
//     legality checks for HIGH_CYCLES / GAP_CYCLES against CNT_W.
//   - One sub-module, pulse_timer: CNT_W-bit down-counter with load value, enable and
//     zero flag. The FSM, pending counter and drop logic live in the top module.
// TESTING  (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=4 unless stated; rst_n released before cycle 5)
//   1. in_pulse @10 -> level_out high 11-14, busy high 11-16, IDLE @17, drop never.
//   2. QUEUE_EN, in_pulse @10,12,13 -> pend_cnt 1@13, 2@14;
//      level_out high 11-14, 17-20, 23-26; pend_cnt 0 after 22; drop never.
//   3. No QUEUE_EN, in_pulse @10,12 -> level_out high 11-14 only;
//      drop high @13 only; pend_cnt always 0.
//   4. QUEUE_EN, PEND_W=2, in_pulse @10,11,12,13,14 -> pend_cnt saturates at 3 @14;
//      drop @15; four HIGH windows total.
//   5. in_pulse @10, rst_n low @13 (async) -> level_out/busy drop to 0 within cycle 13.
//      After release, in_pulse @20 -> level_out high 21-24.
//   6. GAP_CYCLES=0, QUEUE_EN, in_pulse @10,11 -> level_out continuously high 11-18, busy low @19.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: FSM state type and parameter legality check for pulse_stretch
package pulse_stretch_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;
  function automatic bit cycles_legal(int high_cycles, int gap_cycles, int cnt_w);
    return high_cycles >= 1 && high_cycles < (1 << cnt_w) &&
           gap_cycles >= 0 && gap_cycles < (1 << cnt_w);
  endfunction
endpackage

// File: rtl/pulse_stretch_timer.sv
// pulse_timer: CNT_W-bit loadable down-counter with enable and zero flag
module pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = cnt == '0;
  // load wins over counting; the counter parks at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : (en && !zero) ? cnt - CNT_W'(1) : cnt;
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches request pulses into fixed-width levels with a minimum low gap; PULSE_STRETCH_QUEUE_EN queues requests arriving while busy
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_pulse,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              drop
);
  localparam logic [CNT_W-1:0] HI_LD  = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit               NO_GAP = GAP_CYCLES == 0;
  if (!cycles_legal(HIGH_CYCLES, GAP_CYCLES, CNT_W)) begin : g_bad_params
    $error("pulse_stretch: HIGH_CYCLES/GAP_CYCLES out of range for CNT_W");
  end
  state_t state, state_nxt;
  logic zero, load, decide, deq, lost;
  logic [CNT_W-1:0] load_val;
  assign level_out = state == HIGH;
  assign busy      = state != IDLE;
  assign decide    = zero && (state == GAP || (state == HIGH && NO_GAP));
  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .en       (busy),
    .load_val (load_val),
    .zero     (zero)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state and timer reload; decide marks the end of a HIGH+GAP window
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = HI_LD;
    if (state == IDLE && in_pulse) begin
      state_nxt = HIGH;
      load      = 1'b1;
    end else if (decide) begin
      state_nxt = deq ? HIGH : IDLE;
      load      = deq;
    end else if (state == HIGH && zero) begin
      state_nxt = GAP;
      load      = 1'b1;
      load_val  = GAP_LD;
    end
  end
`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic inc, acc;
  // a request landing on the window end is served directly, so IDLE never holds a pending count
  assign inc  = busy && in_pulse;
  assign deq  = decide && (pend_cnt != '0 || in_pulse);
  assign lost = inc && pend_cnt == PEND_MAX && !deq;
  assign acc  = inc && !lost;
  // pending counter: accept and dequeue in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_cnt <= '0;
    else pend_cnt <= (acc && !deq) ? pend_cnt + PEND_W'(1) :
                     (!acc && deq) ? pend_cnt - PEND_W'(1) : pend_cnt;
`else
  assign deq      = 1'b0;
  assign lost     = busy && in_pulse;
  assign pend_cnt = '0;
`endif
  // one-cycle drop strobe after each lost request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop <= 1'b0;
    else drop <= lost;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed tests on three parameter sets against a window-based reference model
module tb_pulse_stretch;
`ifdef PULSE_STRETCH_QUEUE_EN
  localparam bit Q = 1'b1;
`else
  localparam bit Q = 1'b0;
`endif
  typedef struct {
    int hi;
    int gap;
    int pend;
    bit drop;
  } ms_t;
  int hc[3] = '{4, 4, 4};
  int gc[3] = '{2, 2, 0};
  int pm[3] = '{15, 3, 15};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] inp = '0;
  logic [2:0] lvl, bsy, drp;
  logic [3:0] p0, p2;
  logic [1:0] p1;
  int pnd[3];
  ms_t m[3];
  int vectors = 0;
  int miscompares = 0;
  int h_lvl[64], h_busy[64], h_drop[64], h_pend[64];

  always #5 clk = ~clk;

  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .PEND_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_pulse(inp[0]), .level_out(lvl[0]),
    .busy(bsy[0]), .pend_cnt(p0), .drop(drp[0]));
  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .PEND_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_pulse(inp[1]), .level_out(lvl[1]),
    .busy(bsy[1]), .pend_cnt(p1), .drop(drp[1]));
  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8), .PEND_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_pulse(inp[2]), .level_out(lvl[2]),
    .busy(bsy[2]), .pend_cnt(p2), .drop(drp[2]));

  always_comb begin
    pnd[0] = int'(p0);
    pnd[1] = int'(p1);
    pnd[2] = int'(p2);
  end

  // model: hi = high cycles left in the window, gap = low cycles left before the next may start
  function automatic ms_t step(ms_t s, bit p, int h, int g, int pmax);
    ms_t n = s;
    n.drop = 1'b0;
    if (s.hi == 0 && s.gap == 0) begin
      if (p) n.hi = h;
    end else begin
      if (n.hi > 0) begin
        n.hi = n.hi - 1;
        if (n.hi == 0) n.gap = g;
      end else n.gap = n.gap - 1;
      if (n.hi == 0 && n.gap == 0 && Q && (n.pend > 0 || p)) begin
        n.pend = n.pend + int'(p) - 1;
        n.hi = h;
      end else if (p) begin
        if (Q && n.pend < pmax) n.pend = n.pend + 1;
        else n.drop = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++)
      m[i] <= !rst_n ? ms_t'{0, 0, 0, 1'b0} : step(m[i], inp[i], hc[i], gc[i], pm[i]);

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d level_out", i), int'(lvl[i]), int'(m[i].hi > 0));
      chk($sformatf("u%0d busy", i), int'(bsy[i]), int'(m[i].hi > 0 || m[i].gap > 0));
      chk($sformatf("u%0d pend_cnt", i), pnd[i], m[i].pend);
      chk($sformatf("u%0d drop", i), int'(drp[i]), int'(m[i].drop));
    end

  task automatic run(input int sel, input logic [63:0] mask, input int rst_at, input int rel_at, input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      rst_n = (c >= 3) && !(c >= rst_at && c < rel_at);
      inp = '0;
      inp[sel] = mask[c];
      @(negedge clk);
      h_lvl[c] = int'(lvl[sel]);
      h_busy[c] = int'(bsy[sel]);
      h_drop[c] = int'(drp[sel]);
      h_pend[c] = pnd[sel];
    end
    inp = '0;
  endtask

  function automatic int sum_drop(input int len);
    int s = 0;
    for (int c = 0; c < len; c++) s += h_drop[c];
    return s;
  endfunction

  initial begin
    int rises;
    // 1: single request
    run(0, 64'd1 << 10, 99, 99, 22);
    chk("t1 reset level", h_lvl[1], 0);
    chk("t1 reset busy", h_busy[1], 0);
    chk("t1 reset pend", h_pend[1], 0);
    chk("t1 level@10", h_lvl[10], 0);
    chk("t1 level@11", h_lvl[11], 1);
    chk("t1 level@14", h_lvl[14], 1);
    chk("t1 level@15", h_lvl[15], 0);
    chk("t1 busy@16", h_busy[16], 1);
    chk("t1 busy@17", h_busy[17], 0);
    chk("t1 drops", sum_drop(22), 0);
    // 2/3: requests while busy
    run(0, (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 13), 99, 99, 32);
`ifdef PULSE_STRETCH_QUEUE_EN
    chk("t2 pend@13", h_pend[13], 1);
    chk("t2 pend@14", h_pend[14], 2);
    chk("t2 level@16", h_lvl[16], 0);
    chk("t2 level@17", h_lvl[17], 1);
    chk("t2 level@20", h_lvl[20], 1);
    chk("t2 level@21", h_lvl[21], 0);
    chk("t2 level@23", h_lvl[23], 1);
    chk("t2 level@26", h_lvl[26], 1);
    chk("t2 level@27", h_lvl[27], 0);
    chk("t2 pend@23", h_pend[23], 0);
    chk("t2 drops", sum_drop(32), 0);
`else
    chk("t3b level@17", h_lvl[17], 0);
    chk("t3b drops", sum_drop(32), 2);
`endif
    run(0, (64'd1 << 10) | (64'd1 << 12), 99, 99, 22);
`ifndef PULSE_STRETCH_QUEUE_EN
    chk("t3 drop@12", h_drop[12], 0);
    chk("t3 drop@13", h_drop[13], 1);
    chk("t3 drop@14", h_drop[14], 0);
    chk("t3 level@17", h_lvl[17], 0);
    chk("t3 pend@13", h_pend[13], 0);
`endif
    // 4: saturation with PEND_W=2
    run(1, 64'h1F << 10, 99, 99, 38);
    rises = 0;
    for (int c = 1; c < 38; c++) if (h_lvl[c] == 1 && h_lvl[c-1] == 0) rises++;
`ifdef PULSE_STRETCH_QUEUE_EN
    chk("t4 pend@14", h_pend[14], 3);
    chk("t4 drop@15", h_drop[15], 1);
    chk("t4 drops", sum_drop(38), 1);
    chk("t4 windows", rises, 4);
    chk("t4 level@32", h_lvl[32], 1);
    chk("t4 level@33", h_lvl[33], 0);
`else
    chk("t4 drops", sum_drop(38), 4);
    chk("t4 windows", rises, 1);
`endif
    // 5: async reset mid-HIGH
    run(0, (64'd1 << 10) | (64'd1 << 20), 13, 16, 30);
    chk("t5 level@12", h_lvl[12], 1);
    chk("t5 level@13", h_lvl[13], 0);
    chk("t5 busy@13", h_busy[13], 0);
    chk("t5 level@21", h_lvl[21], 1);
    chk("t5 level@24", h_lvl[24], 1);
    chk("t5 level@25", h_lvl[25], 0);
    // 6: zero gap
    run(2, (64'd1 << 10) | (64'd1 << 11), 99, 99, 24);
`ifdef PULSE_STRETCH_QUEUE_EN
    for (int c = 11; c <= 18; c++) chk($sformatf("t6 level@%0d", c), h_lvl[c], 1);
    chk("t6 level@19", h_lvl[19], 0);
    chk("t6 busy@19", h_busy[19], 0);
`else
    chk("t6 level@15", h_lvl[15], 0);
    chk("t6 drop@12", h_drop[12], 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
